prog_word_serializer: RTL and testbench

On-chip host-side serializer that drives the configuration programmer's serial port (SCLK/CS/SDI). It accepts a 64-bit programming word on the system clock and shifts it out MSB first under an active-low chip select. It generates a divided SCLK and guarantees CS setup/hold margins. It sits directly upstream of the programmer block and replaces the hand-written bench stimulus used for register loading.

---
 rtl/prog_word_serializer.sv | 160 ++++++++++++++++
 tb/tb_prog_word_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_word_serializer.sv
// prog_word_serializer: shifts a programming word out MSB first on SCLK/CS/SDI.
// SDI is the MSB of the shift register, so it is a flop output. The register
// fills with zeros as it shifts, which drives SDI low once the last bit is sent.
module prog_word_serializer #(
  parameter int SCLK_HALF = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int WORD_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 SCLK,
  output logic                 CS,
  output logic                 SDI
);

  localparam int P_MAX01 = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
  localparam int P_MAX   = (P_MAX01 > CS_HOLD) ? P_MAX01 : CS_HOLD;
  localparam int PH_W    = $clog2(P_MAX) + 1;
  localparam int BC_W    = $clog2(WORD_BITS) + 1;

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(SCLK_HALF - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                 state_q,  state_d;
  logic [WORD_BITS-1:0]   shreg_q,  shreg_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]        ph_cnt_q, ph_cnt_d;
  logic                   sclk_q,   sclk_d;
  logic                   cs_q,     cs_d;
  logic                   busy_q,   busy_d;
  logic                   done_q,   done_d;

  assign SCLK = sclk_q;
  assign CS   = cs_q;
  assign SDI  = shreg_q[WORD_BITS-1];
  assign busy = busy_q;
  assign done = done_q;

  // Next-state and next-output computation for the serializer FSM.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle is still the tail of the previous transaction.
        if (start && !done_q) begin
          shreg_d   = data_in;
          bit_cnt_d = {BC_W{1'b0}};
          ph_cnt_d  = {PH_W{1'b0}};
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end else begin
          sclk_d = 1'b0;
          cs_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (ph_cnt_q == SETUP_LAST) begin
          sclk_d   = 1'b1;
          ph_cnt_d = {PH_W{1'b0}};
          state_d  = S_HIGH;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_HIGH: begin
        if (ph_cnt_q == HALF_LAST) begin
          // Falling edge: advance SDI; after the last bit a zero shifts up.
          sclk_d   = 1'b0;
          shreg_d  = {shreg_q[WORD_BITS-2:0], 1'b0};
          ph_cnt_d = {PH_W{1'b0}};
          state_d  = S_LOW;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_LOW: begin
        if (ph_cnt_q == HALF_LAST) begin
          ph_cnt_d = {PH_W{1'b0}};
          if (bit_cnt_q != BIT_LAST) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            state_d   = S_HIGH;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_HOLD: begin
        if (ph_cnt_q == HOLD_LAST) begin
          cs_d     = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ph_cnt_d = {PH_W{1'b0}};
          state_d  = S_IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        shreg_d   = {WORD_BITS{1'b0}};
        bit_cnt_d = {BC_W{1'b0}};
        ph_cnt_d  = {PH_W{1'b0}};
        sclk_d    = 1'b0;
        cs_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= {WORD_BITS{1'b0}};
      bit_cnt_q <= {BC_W{1'b0}};
      ph_cnt_q  <= {PH_W{1'b0}};
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_prog_word_serializer.sv
// Bench for prog_word_serializer: instance a uses default timing (2/2/2),
// instance b uses 1/1/1 for the back-to-back run. A monitor rebuilds every
// word from SDI on SCLK rises and checks it against a scoreboard queue.
module tb_prog_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [63:0] data_a = 64'h0;
  logic        busy_a, done_a, sclk_a, cs_a, sdi_a;
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [63:0] data_b = 64'h0;
  logic        busy_b, done_b, sclk_b, cs_b, sdi_b;

  prog_word_serializer dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .data_in(data_a),
    .busy(busy_a), .done(done_a), .SCLK(sclk_a), .CS(cs_a), .SDI(sdi_a)
  );

  prog_word_serializer #(.SCLK_HALF(1), .CS_SETUP(1), .CS_HOLD(1), .WORD_BITS(64)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .data_in(data_b),
    .busy(busy_b), .done(done_b), .SCLK(sclk_b), .CS(cs_b), .SDI(sdi_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  // Per-instance monitor state; index 0 = dut_a, 1 = dut_b.
  int          done_cnt[2];
  int          rises[2];
  int          low_cnt[2];
  int          hi_cnt[2];
  int          fall_at[2];
  logic [63:0] cap[2];
  logic        p_sclk[2], p_cs[2], p_sdi[2];
  bit          gap_chk[2];
  // Expected timing: first rise delay, cycles from last fall to CS rise
  // (final LOW phase plus CS_HOLD), total CS-low length.
  int exp_setup[2] = '{2, 1};
  int exp_tail[2]  = '{4, 2};
  int exp_len[2]   = '{260, 130};

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; rises[i] = 0; low_cnt[i] = 0; hi_cnt[i] = 0; fall_at[i] = 0;
      cap[i] = 64'h0; p_sclk[i] = 1'b0; p_cs[i] = 1'b1; p_sdi[i] = 1'b0; gap_chk[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic s, c, d, dn;
        logic [63:0] ew;
        if (i == 0) {s, c, d, dn} = {sclk_a, cs_a, sdi_a, done_a};
        else        {s, c, d, dn} = {sclk_b, cs_b, sdi_b, done_b};
        if (!c && p_cs[i]) begin
          if (gap_chk[i]) begin
            vectors++;
            if (hi_cnt[i] !== 2) begin
              miscompares++;
              $display("FAIL gap_cs_high[%0d]: got %0d cycles expected 2", i, hi_cnt[i]);
            end
          end
          low_cnt[i] = 0; rises[i] = 0; cap[i] = 64'h0;
        end
        if (c) begin
          if (!p_cs[i]) hi_cnt[i] = 1;
          else          hi_cnt[i] = hi_cnt[i] + 1;
        end else begin
          low_cnt[i] = low_cnt[i] + 1;
        end
        if (d !== p_sdi[i]) begin
          vectors++;
          if (s !== 1'b0) begin
            miscompares++;
            $display("FAIL sdi_stable[%0d]: SDI changed while SCLK=%b", i, s);
          end
        end
        if (s && !p_sclk[i] && !c) begin
          if (rises[i] == 0) begin
            vectors++;
            if (low_cnt[i] - 1 !== exp_setup[i]) begin
              miscompares++;
              $display("FAIL cs_setup[%0d]: got %0d expected %0d", i, low_cnt[i] - 1, exp_setup[i]);
            end
          end
          cap[i] = {cap[i][62:0], d};
          rises[i] = rises[i] + 1;
        end
        if (!s && p_sclk[i] && !c) fall_at[i] = low_cnt[i];
        if (dn) begin
          done_cnt[i] = done_cnt[i] + 1;
          vectors++;
          if ((i == 0 && exp_a.size() == 0) || (i == 1 && exp_b.size() == 0)) begin
            miscompares++;
            $display("FAIL unexpected_done[%0d]: got done with empty scoreboard expected none", i);
          end else begin
            if (i == 0) ew = exp_a.pop_front();
            else        ew = exp_b.pop_front();
            vectors++;
            if (cap[i] !== ew) begin
              miscompares++;
              $display("FAIL word[%0d]: got %h expected %h", i, cap[i], ew);
            end
          end
          vectors++;
          if (rises[i] !== 64) begin
            miscompares++;
            $display("FAIL rise_count[%0d]: got %0d expected 64", i, rises[i]);
          end
          vectors++;
          if (low_cnt[i] !== exp_len[i]) begin
            miscompares++;
            $display("FAIL cs_low_len[%0d]: got %0d expected %0d", i, low_cnt[i], exp_len[i]);
          end
          vectors++;
          if (low_cnt[i] - (fall_at[i] - 1) !== exp_tail[i]) begin
            miscompares++;
            $display("FAIL cs_hold[%0d]: got %0d expected %0d", i, low_cnt[i] - (fall_at[i] - 1), exp_tail[i]);
          end
        end
        p_sclk[i] = s; p_cs[i] = c; p_sdi[i] = d;
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors += 2;
    if ({sclk_a, cs_a, sdi_a, busy_a, done_a} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_a: got sclk/cs/sdi/busy/done=%b expected 01000", {sclk_a, cs_a, sdi_a, busy_a, done_a});
    end
    if ({sclk_b, cs_b, sdi_b, busy_b, done_b} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_b: got sclk/cs/sdi/busy/done=%b expected 01000", {sclk_b, cs_b, sdi_b, busy_b, done_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic(input logic [63:0] w);
    int base = done_cnt[0];
    int t;
    #1;
    data_a = w; start_a = 1'b1; exp_a.push_back(w);
    @(negedge clk); #1;
    start_a = 1'b0;
    vectors++;
    if ({busy_a, cs_a, sdi_a} !== {1'b1, 1'b0, w[63]}) begin
      miscompares++;
      $display("FAIL basic_accept: got busy/cs/sdi=%b expected %b", {busy_a, cs_a, sdi_a}, {1'b1, 1'b0, w[63]});
    end
    for (t = 0; t < 400 && done_cnt[0] == base; t++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (done_cnt[0] == base) begin
      miscompares++;
      $display("FAIL basic_timeout: got no done expected done within 400 cycles");
    end
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt[0] !== base + 1) begin
      miscompares++;
      $display("FAIL basic_done_count: got %0d expected %0d", done_cnt[0] - base, 1);
    end
  endtask

  task automatic test_ignore();
    int base = done_cnt[0];
    int t;
    bit busy_ok = 1'b1;
    logic [63:0] w = 64'h0123_4567_89AB_CDEF;
    #1;
    data_a = w; start_a = 1'b1; exp_a.push_back(w);
    for (t = 1; t < 400; t++) begin
      @(negedge clk); #1;
      if (t == 5 || t == 100) begin
        start_a = 1'b1; data_a = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        start_a = 1'b0;
      end
      if (done_cnt[0] != base) break;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
    end
    start_a = 1'b0;
    vectors++;
    if (!busy_ok) begin
      miscompares++;
      $display("FAIL ignore_busy: got a busy gap expected continuous busy");
    end
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt[0] !== base + 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d expected 1", done_cnt[0] - base);
    end
  endtask

  task automatic test_reset_abort();
    int base = done_cnt[0];
    int t;
    logic [63:0] dropped;
    #1;
    data_a = 64'hA5A5_0F0F_3C3C_9696; start_a = 1'b1; exp_a.push_back(data_a);
    @(negedge clk); #1;
    start_a = 1'b0;
    for (t = 0; t < 200 && rises[0] < 20; t++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (rises[0] != 20) begin
      miscompares++;
      $display("FAIL abort_rise20: got %0d rises expected 20", rises[0]);
    end
    rst_a = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({cs_a, sclk_a, sdi_a, busy_a, done_a} !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort_outputs: got cs/sclk/sdi/busy/done=%b expected 10000", {cs_a, sclk_a, sdi_a, busy_a, done_a});
    end
    rst_a = 1'b0;
    dropped = exp_a.pop_back();
    repeat (300) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt[0] !== base) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0 for %h", done_cnt[0] - base, dropped);
    end
    test_basic(64'h8000_0000_0000_0001);
  endtask

  task automatic test_back_to_back();
    logic [63:0] words[3] = '{64'h02DEECED5990D0D5, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_0000_FFFF};
    int base = done_cnt[1];
    int falls = 0;
    int t;
    logic prev_cs = 1'b1;
    #1;
    data_b = words[0]; exp_b.push_back(words[0]); start_b = 1'b1;
    for (t = 0; t < 1000 && done_cnt[1] < base + 3; t++) begin
      @(negedge clk); #1;
      if (!cs_b && prev_cs) begin
        falls++;
        if (falls == 1) gap_chk[1] = 1'b1;
        if (falls < 3) begin
          data_b = words[falls]; exp_b.push_back(words[falls]);
        end else begin
          start_b = 1'b0;
        end
      end
      prev_cs = cs_b;
    end
    start_b = 1'b0;
    gap_chk[1] = 1'b0;
    vectors++;
    if (falls !== 3) begin
      miscompares++;
      $display("FAIL b2b_transactions: got %0d CS falls expected 3", falls);
    end
    repeat (150) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt[1] !== base + 3) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d expected 3", done_cnt[1] - base);
    end
  endtask

  initial begin
    test_reset();
    test_basic(64'h02DEECED5990D0D5);
    test_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
